// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - TD4 opcodes, default widths, loader states and reset image (PROG_MEM_DEFAULT_IMAGE_EN)
package prog_mem_pkg;

   localparam int PM_ADDR_W = 4;
   localparam int PM_DATA_W = 8;

   localparam logic [3:0] OP_ADD_A   = 4'b0000;
   localparam logic [3:0] OP_MOV_AB  = 4'b0001;
   localparam logic [3:0] OP_IN_A    = 4'b0010;
   localparam logic [3:0] OP_MOV_A   = 4'b0011;
   localparam logic [3:0] OP_MOV_BA  = 4'b0100;
   localparam logic [3:0] OP_ADD_B   = 4'b0101;
   localparam logic [3:0] OP_IN_B    = 4'b0110;
   localparam logic [3:0] OP_MOV_B   = 4'b0111;
   localparam logic [3:0] OP_OUT_B   = 4'b1001;
   localparam logic [3:0] OP_OUT_IMM = 4'b1011;
   localparam logic [3:0] OP_JNC     = 4'b1110;
   localparam logic [3:0] OP_JMP     = 4'b1111;

   typedef enum logic [1:0] {
      LD_IDLE   = 2'd0,
      LD_LOAD   = 2'd1,
      LD_FINISH = 2'd2
   } ld_state_t;

   // Power-on program: LED counter demo when enabled, otherwise all zero.
   function automatic logic [7:0] reset_image(input int idx);
      logic [7:0] b;
      b = 8'h00;
`ifdef PROG_MEM_DEFAULT_IMAGE_EN
      case (idx)
         0:       b = {OP_OUT_B, 4'h0};
         1:       b = {OP_ADD_B, 4'h1};
         2:       b = {OP_JMP, 4'h0};
         default: b = 8'h00;
      endcase
`else
      if (idx < 0) b = 8'h00;
`endif
      return b;
   endfunction

endpackage

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - byte-serial program loader FSM driving the write port of prog_mem
module prog_mem_loader
   import prog_mem_pkg::*;
#(
   parameter int ADDR_W = PM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              cpu_hold,
   output logic              we,
   output logic [ADDR_W-1:0] waddr
);

   ld_state_t         state;
   logic [ADDR_W-1:0] wptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LD_IDLE;
         wptr  <= '0;
      end else begin
         case (state)
            LD_IDLE: begin
               if (ld_start) begin
                  state <= LD_LOAD;
                  wptr  <= '0;
               end
            end
            LD_LOAD: begin
               // A restart takes priority over a byte offered in the same cycle.
               if (ld_start) begin
                  wptr <= '0;
               end else if (ld_valid) begin
                  wptr <= wptr + 1'b1;
                  if (&wptr) state <= LD_FINISH;
               end
            end
            LD_FINISH: state <= LD_IDLE;
            default:   state <= LD_IDLE;
         endcase
      end
   end

   assign ld_ready = (state == LD_LOAD);
   assign ld_done  = (state == LD_FINISH);
   assign cpu_hold = (state != LD_IDLE);
   assign we       = ld_ready & ld_valid & ~ld_start;
   assign waddr    = wptr;

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 16x8 CPU program memory with combinational fetch and serial loader (PROG_MEM_DEFAULT_IMAGE_EN)
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int ADDR_W = PM_ADDR_W,
   parameter int DATA_W = PM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              cpu_hold
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              we;
   logic [ADDR_W-1:0] waddr;

   prog_mem_loader #(.ADDR_W(ADDR_W)) u_loader (
      .clk      (clk),
      .reset    (reset),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_done  (ld_done),
      .cpu_hold (cpu_hold),
      .we       (we),
      .waddr    (waddr)
   );

   // Reset reloads the image, so an interrupted load leaves no partial program.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(reset_image(i));
      end else if (we) begin
         mem[waddr] <= ld_data;
      end
   end

   assign data = mem[addr];

endmodule

// File: tb/tb_prog_mem.sv
// tb/tb_prog_mem.sv - self-checking bench for prog_mem against a behavioural loader model
module tb_prog_mem;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] addr;
   logic [7:0] data;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       ld_done;
   logic       cpu_hold;

   always #5 clk = ~clk;

   prog_mem dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .data     (data),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .ld_done  (ld_done),
      .cpu_hold (cpu_hold)
   );

   logic [7:0] ref_mem [16];
   bit         loading;
   bit         finishing;
   int         accepted;
   int         n_checks = 0;
   int         n_pass   = 0;

   function automatic logic [7:0] image_byte(input int i);
`ifdef PROG_MEM_DEFAULT_IMAGE_EN
      if (i == 0) return 8'h90;
      if (i == 1) return 8'h51;
      if (i == 2) return 8'hF0;
`endif
      return 8'h00;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   // One clock: drive inputs, advance the model across the edge, then check outputs.
   task automatic cycle(input logic rst, input logic st, input logic v,
                        input logic [7:0] d, input int a);
      bit was_loading;
      bit was_finishing;
      @(negedge clk);
      reset    = rst;
      ld_start = st;
      ld_valid = v;
      ld_data  = d;
      addr     = (a < 0) ? 4'($urandom_range(0, 15)) : 4'(a);
      @(posedge clk);
      was_loading   = loading;
      was_finishing = finishing;
      finishing     = 1'b0;
      if (rst) begin
         for (int i = 0; i < 16; i++) ref_mem[i] = image_byte(i);
         loading  = 1'b0;
         accepted = 0;
      end else if (was_loading) begin
         if (st) begin
            accepted = 0;
         end else if (v) begin
            ref_mem[accepted] = d;
            accepted++;
            if (accepted == 16) begin
               loading   = 1'b0;
               finishing = 1'b1;
               accepted  = 0;
            end
         end
      end else if (!was_finishing && st) begin
         loading  = 1'b1;
         accepted = 0;
      end
      #1;
      check("ld_ready", {7'b0, ld_ready}, {7'b0, loading});
      check("cpu_hold", {7'b0, cpu_hold}, {7'b0, loading | finishing});
      check("ld_done",  {7'b0, ld_done},  {7'b0, finishing});
      check($sformatf("data[%0d]", addr), data, ref_mem[addr]);
   endtask

   task automatic sweep();
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, i);
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, 8'($urandom), -1);
      cycle(1'b0, 1'b0, 1'b1, b, -1);
   endtask

   initial begin
      reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; addr = 4'h0;
      loading = 1'b0; finishing = 1'b0; accepted = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'hxx;

      cycle(1'b1, 1'b0, 1'b0, 8'h00, 0);
      cycle(1'b1, 1'b0, 1'b1, 8'h77, 1);
      sweep();

      // Full load with random valid gaps.
      cycle(1'b0, 1'b1, 1'b0, 8'h00, -1);
      for (int k = 0; k < 16; k++) send_byte(8'h10 + 8'(k), 3);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, -1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, -1);
      sweep();

      // Restart after 5 bytes, with valid asserted alongside start.
      cycle(1'b0, 1'b1, 1'b0, 8'h00, -1);
      for (int k = 0; k < 5; k++) send_byte(8'h30 + 8'(k), 2);
      cycle(1'b0, 1'b1, 1'b1, 8'hEE, -1);
      for (int k = 0; k < 16; k++) send_byte(8'h40 + 8'(k), 2);
      sweep();

      // Valid without start in IDLE, then valid plus start during FINISH.
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'hAA, -1);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, -1);
      for (int k = 0; k < 16; k++) send_byte(8'($urandom), 1);
      cycle(1'b0, 1'b1, 1'b1, 8'hAA, -1);
      cycle(1'b0, 1'b0, 1'b1, 8'hAA, -1);
      sweep();

      // Reset part-way through a load restores the reset image.
      cycle(1'b0, 1'b1, 1'b0, 8'h00, -1);
      for (int k = 0; k < 7; k++) send_byte(8'($urandom), 1);
      cycle(1'b1, 1'b0, 1'b1, 8'h55, -1);
      sweep();

      // Random traffic.
      for (int k = 0; k < 300; k++)
         cycle(1'b0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 8'($urandom), -1);
      for (int k = 0; k < 40; k++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), -1);
      sweep();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
